// File: rtl/obi_ram_bank.sv
// Single-port OBI SRAM bank with byte enables and an optional zero-fill after reset.
// Latency: rvalid/rdata one cycle after each handshake; zero-fill takes NUM_WORDS cycles.
// Backpressure: gnt is held low during zero-fill, then follows req with no wait states.

package obi_ram_bank_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_ram_bank
    import obi_ram_bank_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 2048,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  req_i,
    output obi_resp_t resp_o,
    output logic      init_done_o
);

    localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam state_e RST_STATE = INIT_ZERO ? ST_INIT : ST_READY;
    localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            init_done_q, init_done_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     mem_q [NUM_WORDS];

    logic [AW-1:0]   word_idx;
    logic            gnt;
    logic            wr_hs;
    logic            rd_hs;
    logic            clr_en;
    logic [3:0]      lane_we;
    logic [31:0]     lane_wdat;
    logic [AW-1:0]   lane_idx;

    // Bank decoding is done upstream, so high address bits and the byte offset are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_i.addr[31:AW+2], req_i.addr[1:0]};

    // Grant decode: no wait states once ready; never grant while reset is held.
    always_comb begin
        word_idx = req_i.addr[AW+1:2];
        gnt      = (state_q == ST_READY) & req_i.req & rst_ni;
        wr_hs    = gnt & req_i.we;
        rd_hs    = gnt & ~req_i.we;
        clr_en   = (state_q == ST_INIT) & rst_ni;
    end

    // Next-state logic for the zero-fill sequencer and the response pipeline stage.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (clr_cnt_q == LAST_WORD) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
        init_done_d = (state_d == ST_READY);
        rvalid_d    = gnt;
        // Writes answer with zero data; only reads return the stored word.
        rdata_d     = rd_hs ? mem_q[word_idx] : 32'h0;
    end

    // Control and response registers; any pending response is dropped by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= '0;
            init_done_q <= ~INIT_ZERO;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    // Per-lane write port: zero-fill owns the array during init, bus writes afterwards.
    always_comb begin
        lane_we   = 4'b0000;
        lane_wdat = req_i.wdata;
        lane_idx  = word_idx;
        if (clr_en) begin
            lane_we   = 4'b1111;
            lane_wdat = 32'h0;
            lane_idx  = clr_cnt_q;
        end else if (wr_hs) begin
            lane_we   = req_i.be;
        end
    end

    // Storage array; deliberately not reset so contents survive until zero-fill runs.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem_q[lane_idx][8*i +: 8] <= lane_wdat[8*i +: 8];
            end
        end
    end

    assign resp_o.gnt    = gnt;
    assign resp_o.rvalid = rvalid_q;
    assign resp_o.rdata  = rdata_q;
    assign init_done_o   = init_done_q;

endmodule

// File: tb/tb_obi_ram_bank.sv
// Testbench for obi_ram_bank: directed scenarios plus random traffic against a word-array model.
// Latency: checks sampled on the falling edge, one step per clock.
// Backpressure: model predicts gnt from the remaining zero-fill cycle count.

module tb_obi_ram_bank;
    import obi_ram_bank_pkg::*;

    localparam int NW = 16;

    logic      clk;
    logic      rst_n;
    obi_req_t  req;
    obi_resp_t resp;
    logic      done;
    obi_req_t  req0;
    obi_resp_t resp0;
    logic      done0;

    logic [31:0] mem_m [NW];
    int          init_left;
    logic        pend_vld;
    logic [31:0] pend_dat;
    logic [31:0] last_rdata;
    int          n_checks;
    int          n_err;

    obi_ram_bank #(.NUM_WORDS(NW), .INIT_ZERO(1'b1)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .resp_o     (resp),
        .init_done_o(done)
    );

    obi_ram_bank #(.NUM_WORDS(NW), .INIT_ZERO(1'b0)) u_dut0 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req0),
        .resp_o     (resp0),
        .init_done_o(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check outputs at the falling edge, update the model, advance.
    task automatic step(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
        logic        rdy;
        int          idx;
        logic [31:0] mask;
        req.req   = r;
        req.we    = w;
        req.be    = b;
        req.addr  = a;
        req.wdata = d;
        @(negedge clk);
        rdy = (init_left == 0);
        chk("gnt", {31'b0, resp.gnt}, {31'b0, rdy & r});
        chk("init_done", {31'b0, done}, {31'b0, rdy});
        chk("rvalid", {31'b0, resp.rvalid}, {31'b0, pend_vld});
        chk("rdata", resp.rdata, pend_dat);
        last_rdata = resp.rdata;
        if (rdy && r) begin
            idx = int'((a / 4) % NW);
            pend_vld = 1'b1;
            if (w) begin
                mask = 32'h0;
                for (int i = 0; i < 4; i++)
                    if (b[i]) mask = mask | (32'hFF << (8 * i));
                mem_m[idx] = (mem_m[idx] & ~mask) | (d & mask);
                pend_dat = 32'h0;
            end else begin
                pend_dat = mem_m[idx];
            end
        end else begin
            pend_vld = 1'b0;
            pend_dat = 32'h0;
        end
        @(posedge clk);
        #1;
        if (init_left > 0) init_left--;
    endtask

    // Assert reset asynchronously, check the reset-state outputs, then release.
    task automatic do_reset();
        req.req  = 1'b1;
        req0.req = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_gnt", {31'b0, resp.gnt}, 32'h0);
        chk("rst_rvalid", {31'b0, resp.rvalid}, 32'h0);
        chk("rst_rdata", resp.rdata, 32'h0);
        chk("rst_init_done", {31'b0, done}, 32'h0);
        chk("rst_gnt0", {31'b0, resp0.gnt}, 32'h0);
        chk("rst_init_done0", {31'b0, done0}, 32'h1);
        @(posedge clk);
        #1;
        req0.req  = 1'b0;
        rst_n     = 1'b1;
        init_left = NW;
        pend_vld  = 1'b0;
        pend_dat  = 32'h0;
        for (int i = 0; i < NW; i++) mem_m[i] = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        req      = '0;
        req0     = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Zero-fill with a read of 0x3C held pending from the first cycle.
        for (int i = 0; i < NW + 1; i++) step(1'b1, 1'b0, 4'h0, 32'h3C, 32'h0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("init_read_3c", last_rdata, 32'h0);

        // Byte-enable merge.
        step(1'b1, 1'b1, 4'b1111, 32'h8, 32'hAABBCCDD);
        step(1'b1, 1'b1, 4'b0101, 32'h8, 32'h11223344);
        step(1'b1, 1'b0, 4'b0000, 32'h8, 32'h0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("merge", last_rdata, 32'hAA22CC44);

        // Streaming reads at one per cycle.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'hF, 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, 32'(4 * i), 32'h0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("stream_last", last_rdata, 32'h4);

        // Address aliasing.
        step(1'b1, 1'b1, 4'hF, 32'h44, 32'hDEADBEEF);
        step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h7, 32'h0);
        chk("alias_0x4", last_rdata, 32'hDEADBEEF);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("alias_0x7", last_rdata, 32'hDEADBEEF);

        // Lone write response, then idle.
        step(1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 32'h20, 32'h0);

        // Randomized traffic with arbitrary high address bits and byte enables.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), $urandom, $urandom);

        // Reset in READY with a read response pending.
        step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        do_reset();
        for (int i = 0; i < NW + 1; i++) step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset part-way through the zero-fill restarts it from word 0.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        do_reset();
        for (int i = 0; i < NW + 1; i++) step(1'b1, 1'b1, 4'hF, 32'h28, 32'hCAFEF00D);
        step(1'b1, 1'b0, 4'h0, 32'h28, 32'h0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("post_restart_read", last_rdata, 32'hCAFEF00D);

        // Bank without zero-fill is usable straight out of reset.
        req.req    = 1'b0;
        req0.req   = 1'b1;
        req0.we    = 1'b1;
        req0.be    = 4'hF;
        req0.addr  = 32'h10;
        req0.wdata = 32'h5A5A1234;
        @(negedge clk);
        chk("nz_gnt", {31'b0, resp0.gnt}, 32'h1);
        chk("nz_init_done", {31'b0, done0}, 32'h1);
        @(posedge clk);
        #1;
        req0.we = 1'b0;
        @(negedge clk);
        chk("nz_wr_rvalid", {31'b0, resp0.rvalid}, 32'h1);
        chk("nz_wr_rdata", resp0.rdata, 32'h0);
        @(posedge clk);
        #1;
        req0.req = 1'b0;
        @(negedge clk);
        chk("nz_rd_rvalid", {31'b0, resp0.rvalid}, 32'h1);
        chk("nz_rd_rdata", resp0.rdata, 32'h5A5A1234);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("nz_idle_rvalid", {31'b0, resp0.rvalid}, 32'h0);
        chk("nz_idle_rdata", resp0.rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
